// File: rtl/pfu_pkg.sv
// Shared types and helpers for the program fetch unit.
// Parity storage is enabled by defining PFU_PARITY_EN.
package pfu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } pfu_state_e;

  localparam int unsigned PAR_MAX_W = 64;

  // Even parity: returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/pfu_if.sv
// Load-stream and fetch-side signals of the program fetch unit.
// parity_err exists only when PFU_PARITY_EN is defined.
interface pfu_if #(
  parameter int unsigned IW = 12,
  parameter int unsigned AW = 8
);
  logic          load_start;
  logic [AW-1:0] load_base;
  logic          load_valid;
  logic [IW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          load_done;
  logic          run_en;
  logic          stall;
  logic          branch_en;
  logic [AW-1:0] branch_addr;
  logic [AW-1:0] pc;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          busy;
`ifdef PFU_PARITY_EN
  logic          parity_err;
`endif

  modport master (
    output load_start, load_base, load_valid, load_data, load_last,
    output run_en, stall, branch_en, branch_addr,
`ifdef PFU_PARITY_EN
    input  parity_err,
`endif
    input  load_ready, load_done, pc, instr, instr_valid, busy
  );

  modport slave (
    input  load_start, load_base, load_valid, load_data, load_last,
    input  run_en, stall, branch_en, branch_addr,
`ifdef PFU_PARITY_EN
    output parity_err,
`endif
    output load_ready, load_done, pc, instr, instr_valid, busy
  );

endinterface

// File: rtl/pfu_mem.sv
// Instruction store: one synchronous write port, one synchronous read port, no reset.
module pfu_mem #(
  parameter int unsigned W     = 12,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_fetch_unit.sv
// Program store with PC and fetch sequencer: loads an image over a valid/ready stream, then fetches.
// Define PFU_PARITY_EN to store an even-parity bit per word and report parity_err on fetch.
module prog_fetch_unit
  import pfu_pkg::*;
#(
  parameter int unsigned IW       = 12,
  parameter int unsigned AW       = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned RESET_PC = 0
) (
  input  logic  clk,
  input  logic  rst_n,
  pfu_if.slave  bus
);

`ifdef PFU_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned MW = IW + PAR_W;

  pfu_state_e    state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] wr_addr_q;
  logic          instr_valid_q;
  logic          load_ready_q;
  logic          load_done_q;
  logic          rd_seen_q;

  logic          mem_we_c;
  logic          mem_re_c;
  logic [MW-1:0] wdata_c;
  logic [MW-1:0] rdata_c;

  function automatic logic [AW-1:0] mod_depth(input logic [AW-1:0] a);
    return AW'(32'(a) % DEPTH);
  endfunction

  // Address increment that wraps at DEPTH-1 rather than at 2**AW-1.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (32'(a) == DEPTH - 1) ? '0 : a + AW'(1);
  endfunction

  assign mem_we_c = (state_q == ST_LOAD) && bus.load_valid && load_ready_q;
  assign mem_re_c = (state_q == ST_RUN) && bus.run_en && !bus.stall;

`ifdef PFU_PARITY_EN
  assign wdata_c = {even_parity(PAR_MAX_W'(bus.load_data)), bus.load_data};
`else
  assign wdata_c = bus.load_data;
`endif

  pfu_mem #(.W(MW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (mem_we_c),
    .waddr_i (wr_addr_q),
    .wdata_i (wdata_c),
    .re_i    (mem_re_c),
    .raddr_i (pc_q),
    .rdata_o (rdata_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= AW'(RESET_PC);
      wr_addr_q     <= '0;
      instr_valid_q <= 1'b0;
      load_ready_q  <= 1'b0;
      load_done_q   <= 1'b0;
      rd_seen_q     <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      if (mem_re_c) rd_seen_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.load_start) begin
            state_q      <= ST_LOAD;
            wr_addr_q    <= mod_depth(bus.load_base);
            load_ready_q <= 1'b1;
          end else if (bus.run_en) begin
            state_q <= ST_RUN;
            pc_q    <= AW'(RESET_PC);
          end
        end
        ST_LOAD: begin
          if (mem_we_c) begin
            wr_addr_q <= next_addr(wr_addr_q);
            if (bus.load_last) begin
              state_q      <= ST_IDLE;
              load_ready_q <= 1'b0;
              load_done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Stall outranks branch; a stalled branch is dropped, the driver must hold it.
          if (!bus.run_en) begin
            state_q       <= ST_IDLE;
            instr_valid_q <= 1'b0;
          end else if (!bus.stall) begin
            instr_valid_q <= 1'b1;
            pc_q          <= bus.branch_en ? mod_depth(bus.branch_addr) : next_addr(pc_q);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The read register has no reset, so instr reads as zero until the first fetch.
  assign bus.instr       = rd_seen_q ? rdata_c[IW-1:0] : '0;
  assign bus.pc          = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.load_ready  = load_ready_q;
  assign bus.load_done   = load_done_q;
  assign bus.busy        = (state_q != ST_IDLE);

`ifdef PFU_PARITY_EN
  assign bus.parity_err = rd_seen_q & (^rdata_c);
`endif

endmodule

// File: tb/tb_prog_fetch_unit.sv
// Bench for prog_fetch_unit: directed scenarios plus random traffic against a behavioural model.
// Define PFU_PARITY_EN to also exercise parity_err.
module tb_prog_fetch_unit;

  localparam int unsigned IW = 12;
  localparam int unsigned AW = 8;
  localparam int unsigned DEPTH = 256;
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pfu_if #(.IW(IW), .AW(AW)) bus ();

  prog_fetch_unit #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural model state
  logic [IW-1:0] m_mem [DEPTH];
  logic          m_bad [DEPTH];
  int            m_mode;
  logic [AW-1:0] m_pc, m_wr;
  logic [IW-1:0] m_instr;
  logic          m_valid, m_ready, m_done, m_perr;

  int errors = 0;
  int checks = 0;

  function automatic logic [23:0] dut_vec();
    return {bus.pc, bus.instr, bus.instr_valid, bus.load_ready, bus.load_done, bus.busy};
  endfunction

  function automatic logic [23:0] mod_vec();
    return {m_pc, m_instr, m_valid, m_ready, m_done, 1'(m_mode != M_IDLE)};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = '0; m_wr = '0; m_instr = '0;
    m_valid = 1'b0; m_ready = 1'b0; m_done = 1'b0; m_perr = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.load_start = 0; bus.load_base = '0; bus.load_valid = 0; bus.load_data = '0;
    bus.load_last = 0; bus.run_en = 0; bus.stall = 0; bus.branch_en = 0; bus.branch_addr = '0;
  endtask

  // Advance one clock, updating the model from the inputs presented before the edge.
  task automatic tick();
    m_done = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (bus.load_start) begin
          m_mode = M_LOAD; m_wr = AW'(int'(bus.load_base) % DEPTH); m_ready = 1'b1;
        end else if (bus.run_en) begin
          m_mode = M_RUN; m_pc = '0;
        end
      end
      M_LOAD: begin
        if (bus.load_valid) begin
          m_mem[m_wr] = bus.load_data;
          m_bad[m_wr] = 1'b0;
          m_wr = AW'((int'(m_wr) + 1) % DEPTH);
          if (bus.load_last) begin m_mode = M_IDLE; m_ready = 1'b0; m_done = 1'b1; end
        end
      end
      default: begin
        if (!bus.run_en) begin
          m_mode = M_IDLE; m_valid = 1'b0;
        end else if (!bus.stall) begin
          m_instr = m_mem[m_pc];
          m_perr  = m_bad[m_pc];
          m_valid = 1'b1;
          m_pc = bus.branch_en ? AW'(int'(bus.branch_addr) % DEPTH) : AW'((int'(m_pc) + 1) % DEPTH);
        end
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    model_reset();
    for (int i = 0; i < DEPTH; i++) m_bad[i] = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== mod_vec()) begin
      errors++; $display("FAIL reset_state: got %h exp %h", dut_vec(), mod_vec());
    end
  endtask

  task automatic test_full_load();
    bus.load_start = 1; bus.load_base = '0;
    tick();
    bus.load_start = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.load_valid = 1; bus.load_data = IW'($urandom); bus.load_last = (i == DEPTH - 1);
      tick();
      checks++;
      if (dut_vec() !== mod_vec()) begin
        errors++; $display("FAIL full_load word %0d: got %h exp %h", i, dut_vec(), mod_vec());
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (dut_vec() !== mod_vec()) begin
      errors++; $display("FAIL full_load_after_done: got %h exp %h", dut_vec(), mod_vec());
    end
  endtask

  task automatic test_reset_midrun();
    int n = 0;
    bus.run_en = 1;
    tick();
    while (m_pc != 8'h37 && n < 300) begin tick(); n++; end
    checks++;
    if (dut_vec() !== mod_vec() || bus.pc !== 8'h37) begin
      errors++; $display("FAIL run_to_37: got %h exp %h", dut_vec(), mod_vec());
    end
    #2 rst_n = 1'b0;
    bus.run_en = 0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== 24'h0) begin
      errors++; $display("FAIL async_reset_midrun: got %h exp %h", dut_vec(), 24'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_wrap();
    logic [IW-1:0] words [3];
    int dones = 0;
    words[0] = 12'hA01; words[1] = 12'hA02; words[2] = 12'hA03;
    bus.load_start = 1; bus.load_base = 8'hFE;
    tick();
    bus.load_start = 0;
    for (int i = 0; i < 3; i++) begin
      bus.load_valid = 1; bus.load_data = words[i]; bus.load_last = (i == 2);
      tick();
      if (bus.load_done) dones++;
    end
    idle_inputs();
    checks++;
    if (dut_vec() !== mod_vec() || bus.load_ready !== 1'b0) begin
      errors++; $display("FAIL load_wrap_done: got %h exp %h", dut_vec(), mod_vec());
    end
    tick();
    if (bus.load_done) dones++;
    checks++;
    if (dones != 1) begin
      errors++; $display("FAIL load_done_pulses: got %0d exp 1", dones);
    end
    bus.run_en = 1;
    tick();
    bus.branch_en = 1; bus.branch_addr = 8'hFE;
    tick();
    bus.branch_en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dut_vec() !== mod_vec() || bus.instr !== words[i]) begin
        errors++; $display("FAIL wrap_readback %0d: got %h exp %h instr %h", i, dut_vec(), mod_vec(), words[i]);
      end
    end
    bus.run_en = 0;
    tick();
  endtask

  task automatic test_load_gap();
    logic       vpat [6];
    logic [IW-1:0] w [4];
    int k = 0;
    vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1; vpat[4] = 1; vpat[5] = 1;
    for (int i = 0; i < 4; i++) w[i] = IW'($urandom);
    bus.load_start = 1; bus.load_base = '0;
    tick();
    bus.load_start = 0;
    for (int c = 0; c < 6; c++) begin
      bus.load_valid = vpat[c];
      bus.load_data  = vpat[c] ? w[k] : IW'($urandom);
      bus.load_last  = vpat[c] && (k == 3);
      if (vpat[c]) k++;
      tick();
      checks++;
      if (dut_vec() !== mod_vec()) begin
        errors++; $display("FAIL load_gap cyc %0d: got %h exp %h", c, dut_vec(), mod_vec());
      end
    end
    idle_inputs();
    bus.run_en = 1;
    tick();
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL gap_first_cycle_valid: got %b exp 0", bus.instr_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dut_vec() !== mod_vec() || (i < 4 && bus.instr !== w[i])) begin
        errors++; $display("FAIL gap_readback %0d: got %h exp %h", i, dut_vec(), mod_vec());
      end
    end
  endtask

  task automatic test_branch();
    int n = 0;
    bus.run_en = 0;
    tick();
    bus.run_en = 1;
    tick();
    while (m_pc != 8'd3 && n < 10) begin tick(); n++; end
    bus.branch_en = 1; bus.branch_addr = 8'h10;
    tick();
    bus.branch_en = 0;
    checks++;
    if (dut_vec() !== mod_vec() || bus.pc !== 8'h10) begin
      errors++; $display("FAIL branch_pc: got %h exp %h", dut_vec(), mod_vec());
    end
    tick();
    checks++;
    if (dut_vec() !== mod_vec() || bus.instr !== m_mem[16]) begin
      errors++; $display("FAIL branch_target_instr: got %h exp %h", bus.instr, m_mem[16]);
    end
  endtask

  task automatic test_stall();
    logic [AW-1:0] pc0 = bus.pc;
    logic [IW-1:0] in0 = bus.instr;
    bus.stall = 1; bus.branch_en = 1; bus.branch_addr = 8'h80;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.pc !== pc0 || bus.instr !== in0 || dut_vec() !== mod_vec()) begin
        errors++; $display("FAIL stall_hold %0d: got pc=%h instr=%h exp pc=%h instr=%h", i, bus.pc, bus.instr, pc0, in0);
      end
    end
    bus.stall = 0; bus.branch_en = 0;
    tick();
    checks++;
    if (bus.pc !== AW'(pc0 + 1) || dut_vec() !== mod_vec()) begin
      errors++; $display("FAIL stall_release: got pc=%h exp pc=%h", bus.pc, AW'(pc0 + 1));
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.load_start  = ($urandom_range(0, 99) < 4);
      bus.load_base   = AW'($urandom);
      bus.load_valid  = ($urandom_range(0, 99) < 60);
      bus.load_data   = IW'($urandom);
      bus.load_last   = ($urandom_range(0, 99) < 15);
      bus.run_en      = ($urandom_range(0, 99) < 85);
      bus.stall       = ($urandom_range(0, 99) < 20);
      bus.branch_en   = ($urandom_range(0, 99) < 10);
      bus.branch_addr = AW'($urandom);
      tick();
      checks++;
      if (dut_vec() !== mod_vec()) begin
        errors++; $display("FAIL random cyc %0d: got %h exp %h", c, dut_vec(), mod_vec());
      end
    end
    idle_inputs();
    tick();
  endtask

`ifdef PFU_PARITY_EN
  task automatic test_parity();
    bus.run_en = 0;
    tick();
    dut.u_mem.mem_q[5][IW] = ~dut.u_mem.mem_q[5][IW];
    m_bad[5] = 1'b1;
    bus.run_en = 1;
    tick();
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (bus.parity_err !== m_perr || dut_vec() !== mod_vec()) begin
        errors++; $display("FAIL parity fetch %0d: got %b exp %b", i, bus.parity_err, m_perr);
      end
    end
    bus.run_en = 0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_full_load();
    test_reset_midrun();
    test_load_wrap();
    test_load_gap();
    test_branch();
    test_stall();
    test_random();
`ifdef PFU_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
